// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage holding the PC, a word-addressed imem and the IF/ID register
module fetch_stage #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Hazard,
  input  logic              PCSrc,
  input  logic [31:0]       BranchTarget,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [31:0]       pc_out,
  output logic [31:0]       IF_ID_Inst,
  output logic [31:0]       IF_ID_NewPC,
  output logic              IF_ID_Valid
);
  logic [31:0] imem [2**ADDR_W];
  logic [31:0] pc_q, pc_d, inst_q, inst_d, npc_q, npc_d, pc_inc, rd_word;
  logic        valid_q, valid_d;
  assign pc_inc  = pc_q + 32'd4;
  assign rd_word = imem[pc_q[ADDR_W+1:2]];
  always_comb begin
    pc_d    = PCSrc ? (BranchTarget & ~32'd3) : Hazard ? pc_q : pc_inc;
    inst_d  = PCSrc ? 32'd0 : Hazard ? inst_q : rd_word;
    npc_d   = PCSrc ? 32'd0 : Hazard ? npc_q : pc_inc;
    valid_d = PCSrc ? 1'b0 : Hazard ? valid_q : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end
  assign pc_out      = pc_q;
  assign IF_ID_Inst  = inst_q;
  assign IF_ID_NewPC = npc_q;
  assign IF_ID_Valid = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Hazard = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = 8'd0;
  logic [31:0] imem_wdata = 32'd0;
  logic [31:0] pc_out, IF_ID_Inst, IF_ID_NewPC;
  logic        IF_ID_Valid;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  localparam logic [31:0] NEW_WORD = 32'hDEAD_BEEF;

  fetch_stage #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .Hazard(Hazard), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc_out(pc_out), .IF_ID_Inst(IF_ID_Inst),
    .IF_ID_NewPC(IF_ID_NewPC), .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".pc"},    pc_out,             e.pc);
      check({e.tag, ".inst"},  IF_ID_Inst,         e.inst);
      check({e.tag, ".npc"},   IF_ID_NewPC,        e.npc);
      check({e.tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, e.valid});
    end
  end

  task automatic cyc(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] npc, input logic valid);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = tag; e.pc = pc; e.inst = inst; e.npc = npc; e.valid = valid;
    exp_q.push_back(e);
  endtask

  initial begin
    imem_we = 1'b1;
    for (int k = 0; k < 256; k++) begin
      imem_waddr = 8'(k);
      imem_wdata = w(k);
      @(posedge clk);
      #1;
    end
    imem_we = 1'b0;
    cyc("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    cyc("run1", 32'd4,  w(0), 32'd4,  1'b1);
    cyc("run2", 32'd8,  w(1), 32'd8,  1'b1);
    cyc("run3", 32'd12, w(2), 32'd12, 1'b1);
    cyc("run4", 32'd16, w(3), 32'd16, 1'b1);
    reset = 1'b1;
    cyc("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    cyc("h_pre1", 32'd4, w(0), 32'd4, 1'b1);
    cyc("h_pre2", 32'd8, w(1), 32'd8, 1'b1);
    Hazard = 1'b1;
    cyc("stall1", 32'd8, w(1), 32'd8, 1'b1);
    cyc("stall2", 32'd8, w(1), 32'd8, 1'b1);
    Hazard = 1'b0;
    cyc("resume", 32'd12, w(2), 32'd12, 1'b1);
    reset = 1'b1;
    cyc("rst3", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    cyc("b_pre1", 32'd4, w(0), 32'd4, 1'b1);
    cyc("b_pre2", 32'd8, w(1), 32'd8, 1'b1);
    PCSrc = 1'b1; BranchTarget = 32'h40;
    cyc("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    PCSrc = 1'b0;
    cyc("b_tgt", 32'h44, w(16), 32'h44, 1'b1);
    PCSrc = 1'b1; Hazard = 1'b1; BranchTarget = 32'h23;
    cyc("br_hz", 32'h20, 32'h0, 32'h0, 1'b0);
    PCSrc = 1'b0; Hazard = 1'b0;
    cyc("br_hz_tgt", 32'h24, w(8), 32'h24, 1'b1);
    PCSrc = 1'b1; BranchTarget = 32'h0C;
    cyc("to_0c", 32'h0C, 32'h0, 32'h0, 1'b0);
    PCSrc = 1'b0;
    cyc("at_10", 32'h10, w(3), 32'h10, 1'b1);
    reset = 1'b1;
    cyc("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    cyc("refetch", 32'd4, w(0), 32'd4, 1'b1);
    cyc("w_pre", 32'd8, w(1), 32'd8, 1'b1);
    imem_we = 1'b1; imem_waddr = 8'd2; imem_wdata = NEW_WORD;
    cyc("w_old", 32'd12, w(2), 32'd12, 1'b1);
    imem_we = 1'b0; PCSrc = 1'b1; BranchTarget = 32'd8;
    cyc("w_back", 32'd8, 32'h0, 32'h0, 1'b0);
    PCSrc = 1'b0;
    cyc("w_new", 32'd12, NEW_WORD, 32'd12, 1'b1);
    PCSrc = 1'b1; BranchTarget = 32'h3FC;
    cyc("to_3fc", 32'h3FC, 32'h0, 32'h0, 1'b0);
    PCSrc = 1'b0;
    cyc("idx255", 32'h400, w(255), 32'h400, 1'b1);
    cyc("alias0", 32'h404, w(0), 32'h404, 1'b1);
    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    cyc("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    PCSrc = 1'b0;
    cyc("pc_wrap", 32'h0, w(255), 32'h0, 1'b1);
    cyc("after_wrap", 32'd4, w(0), 32'd4, 1'b1);
    reset = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h80;
    cyc("rst_over_br", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0; PCSrc = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
